// File: rtl/mult_cdb_arbiter.sv
// Completion controller for the two multiplier lanes: per-lane skid FIFOs,
// round-robin arbitration onto the shared CDB/PRF write slot, and issue credits.
module mult_cdb_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned CRD_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         rs_issue,
  input  logic [1:0]         mult_done,
  input  logic [63:0]        mult_result0,
  input  logic [63:0]        mult_result1,
  input  logic [6:0]         mult_dest_pr_idx0,
  input  logic [6:0]         mult_dest_pr_idx1,
  input  logic [4:0]         mult_dest_ar_idx0,
  input  logic [4:0]         mult_dest_ar_idx1,
  input  logic               cdb_grant,
  output logic               cdb_valid,
  output logic               cdb_lane,
  output logic [63:0]        cdb_result,
  output logic [6:0]         cdb_dest_pr_idx,
  output logic [4:0]         cdb_dest_ar_idx,
  output logic               prf_write_enable,
  output logic [1:0]         rs_mult_avail,
  output logic               overflow_err
);

  typedef enum logic {ARB_OPEN, ARB_HELD} arb_state_t;

  logic [63:0]      res_mem [2][DEPTH];
  logic [6:0]       pr_mem  [2][DEPTH];
  logic [4:0]       ar_mem  [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [PTR_W:0]   count_q  [2];
  logic [CRD_W-1:0] credit_q [2];

  arb_state_t state_q, state_d;
  logic       lock_lane_q, lock_lane_d;
  logic       rr_q, rr_d;
  logic       overflow_q;

  logic [63:0] in_result [2];
  logic [6:0]  in_pr     [2];
  logic [4:0]  in_ar     [2];

  logic [1:0] not_empty, full, crd_zero, pop, push_ok, push_err;
  logic       sel, offer, fire;

  always_comb begin
    in_result[0] = mult_result0;
    in_result[1] = mult_result1;
    in_pr[0]     = mult_dest_pr_idx0;
    in_pr[1]     = mult_dest_pr_idx1;
    in_ar[0]     = mult_dest_ar_idx0;
    in_ar[1]     = mult_dest_ar_idx1;
  end

  always_comb begin
    not_empty = '0;
    full      = '0;
    crd_zero  = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      not_empty[i] = (count_q[i] != '0);
      full[i]      = (count_q[i] == (PTR_W+1)'(DEPTH));
      crd_zero[i]  = (credit_q[i] == '0);
    end
  end

  // Arbitration FSM: HELD pins the lane while an offer waits for a grant.
  always_comb begin
    state_d     = state_q;
    lock_lane_d = lock_lane_q;
    rr_d        = rr_q;
    offer       = (state_q == ARB_HELD) | (|not_empty);

    if (state_q == ARB_HELD)      sel = lock_lane_q;
    else if (not_empty == 2'b01)  sel = 1'b0;
    else if (not_empty == 2'b10)  sel = 1'b1;
    else                          sel = rr_q;

    fire = offer & cdb_grant;
    if (fire) begin
      state_d = ARB_OPEN;
      rr_d    = ~sel;
    end else if (offer) begin
      state_d     = ARB_HELD;
      lock_lane_d = sel;
    end

    pop      = fire ? (sel ? 2'b10 : 2'b01) : 2'b00;
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    push_ok  = mult_done & (~full | pop);
    push_err = mult_done & full & ~pop;
  end

  always_comb begin
    cdb_valid        = offer;
    cdb_lane         = offer & sel;
    cdb_result       = offer ? res_mem[sel][rd_ptr_q[sel]] : '0;
    cdb_dest_pr_idx  = offer ? pr_mem[sel][rd_ptr_q[sel]]  : '0;
    cdb_dest_ar_idx  = offer ? ar_mem[sel][rd_ptr_q[sel]]  : '0;
    prf_write_enable = fire;
    rs_mult_avail    = ~crd_zero;
    overflow_err     = overflow_q;
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push_ok[i]) begin
        res_mem[i][wr_ptr_q[i]] <= in_result[i];
        pr_mem[i][wr_ptr_q[i]]  <= in_pr[i];
        ar_mem[i][wr_ptr_q[i]]  <= in_ar[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_OPEN;
      lock_lane_q <= 1'b0;
      rr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_lane_q <= lock_lane_d;
      rr_q        <= rr_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        credit_q[i] <= CRD_W'(DEPTH);
      end
      overflow_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push_ok[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])     rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        case ({push_ok[i], pop[i]})
          2'b10:   count_q[i] <= count_q[i] + (PTR_W+1)'(1);
          2'b01:   count_q[i] <= count_q[i] - (PTR_W+1)'(1);
          default: ;
        endcase
        // Issue and retire in the same cycle cancel; an issue at zero saturates.
        case ({rs_issue[i], pop[i]})
          2'b10:   if (!crd_zero[i]) credit_q[i] <= credit_q[i] - CRD_W'(1);
          2'b01:   credit_q[i] <= credit_q[i] + CRD_W'(1);
          default: ;
        endcase
      end
      if ((|push_err) | (|(rs_issue & crd_zero))) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_cdb_arbiter.sv
// Directed and randomized bench for mult_cdb_arbiter against a queue-based
// model of the lane FIFOs, arbitration and credits.
module tb_mult_cdb_arbiter;
  localparam int DEPTH = 4;

  logic        clock, reset;
  logic [1:0]  rs_issue, mult_done;
  logic [63:0] mult_result0, mult_result1;
  logic [6:0]  mult_dest_pr_idx0, mult_dest_pr_idx1;
  logic [4:0]  mult_dest_ar_idx0, mult_dest_ar_idx1;
  logic        cdb_grant;
  logic        cdb_valid, cdb_lane, prf_write_enable, overflow_err;
  logic [63:0] cdb_result;
  logic [6:0]  cdb_dest_pr_idx;
  logic [4:0]  cdb_dest_ar_idx;
  logic [1:0]  rs_mult_avail;

  mult_cdb_arbiter #(.DEPTH(4), .PTR_W(2), .CRD_W(3)) dut (
    .clock(clock), .reset(reset), .rs_issue(rs_issue), .mult_done(mult_done),
    .mult_result0(mult_result0), .mult_result1(mult_result1),
    .mult_dest_pr_idx0(mult_dest_pr_idx0), .mult_dest_pr_idx1(mult_dest_pr_idx1),
    .mult_dest_ar_idx0(mult_dest_ar_idx0), .mult_dest_ar_idx1(mult_dest_ar_idx1),
    .cdb_grant(cdb_grant), .cdb_valid(cdb_valid), .cdb_lane(cdb_lane),
    .cdb_result(cdb_result), .cdb_dest_pr_idx(cdb_dest_pr_idx),
    .cdb_dest_ar_idx(cdb_dest_ar_idx), .prf_write_enable(prf_write_enable),
    .rs_mult_avail(rs_mult_avail), .overflow_err(overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] r;
    logic [6:0]  p;
    logic [4:0]  a;
  } ent_t;

  ent_t mq0[$];
  ent_t mq1[$];
  int   m_credit [2];
  int   inflight [2];
  bit   m_lock, m_err;
  int   m_lk, m_rr;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    mq0.delete();
    mq1.delete();
    for (int i = 0; i < 2; i++) begin
      m_credit[i] = DEPTH;
      inflight[i] = 0;
    end
    m_lock = 0; m_err = 0; m_lk = 0; m_rr = 0;
  endtask

  task automatic clr();
    rs_issue = '0; mult_done = '0; cdb_grant = 1'b0;
    mult_result0 = '0; mult_result1 = '0;
    mult_dest_pr_idx0 = '0; mult_dest_pr_idx1 = '0;
    mult_dest_ar_idx0 = '0; mult_dest_ar_idx1 = '0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic cyc();
    bit   v, popi, iss;
    int   s, s0, s1;
    ent_t h;
    @(negedge clock);
    s0 = mq0.size();
    s1 = mq1.size();
    v  = m_lock || s0 > 0 || s1 > 0;
    if (m_lock)                s = m_lk;
    else if (s0 > 0 && s1 == 0) s = 0;
    else if (s0 == 0 && s1 > 0) s = 1;
    else                       s = m_rr;
    h = '0;
    if (v) begin
      if (s == 1) h = mq1[0];
      else        h = mq0[0];
    end
    chk("valid", cdb_valid, v);
    if (v) chk("lane", cdb_lane, s);
    chk("result", cdb_result, h.r);
    chk("dest_pr", cdb_dest_pr_idx, h.p);
    chk("dest_ar", cdb_dest_ar_idx, h.a);
    chk("prf_we", prf_write_enable, v && cdb_grant);
    chk("avail", rs_mult_avail, {m_credit[1] != 0, m_credit[0] != 0});
    chk("ovf_err", overflow_err, m_err);

    @(posedge clock);
    if (v && cdb_grant) begin
      if (s == 1) void'(mq1.pop_front());
      else        void'(mq0.pop_front());
      m_lock = 0;
      m_rr   = 1 - s;
    end else if (v) begin
      m_lock = 1;
      m_lk   = s;
    end
    if (mult_done[0]) begin
      if (mq0.size() == DEPTH) m_err = 1;
      else mq0.push_back({mult_result0, mult_dest_pr_idx0, mult_dest_ar_idx0});
    end
    if (mult_done[1]) begin
      if (mq1.size() == DEPTH) m_err = 1;
      else mq1.push_back({mult_result1, mult_dest_pr_idx1, mult_dest_ar_idx1});
    end
    for (int i = 0; i < 2; i++) begin
      popi = v && cdb_grant && (s == i);
      iss  = rs_issue[i];
      if (iss && m_credit[i] == 0) m_err = 1;
      if (iss && !popi && m_credit[i] > 0) m_credit[i]--;
      else if (!iss && popi) m_credit[i]++;
      if (iss) inflight[i]++;
      if (mult_done[i] && inflight[i] > 0) inflight[i]--;
    end
    #1;
  endtask

  task automatic rand_cycle();
    clr();
    for (int i = 0; i < 2; i++) begin
      if (m_credit[i] > inflight[i] - inflight[i] && m_credit[i] > 0 && ($urandom % 2) == 1)
        rs_issue[i] = 1'b1;
      if (inflight[i] > 0 && ($urandom % 3) == 0) mult_done[i] = 1'b1;
    end
    mult_result0 = {$urandom, $urandom};
    mult_result1 = {$urandom, $urandom};
    mult_dest_pr_idx0 = 7'($urandom); mult_dest_pr_idx1 = 7'($urandom);
    mult_dest_ar_idx0 = 5'($urandom); mult_dest_ar_idx1 = 5'($urandom);
    cdb_grant = ($urandom % 4) != 0;
    cyc();
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    m_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    m_reset();
    #12;
    reset = 1'b0;
    @(posedge clock);
    #1;
    cyc();
    chk("rst_avail", rs_mult_avail, 2'b11);

    // 1: single op, done five cycles after issue
    rs_issue = 2'b01; cyc(); clr();
    repeat (4) cyc();
    mult_done = 2'b01; mult_result0 = 64'h2A; mult_dest_pr_idx0 = 7'd7;
    mult_dest_ar_idx0 = 5'd3; cdb_grant = 1'b1; cyc();
    clr(); cdb_grant = 1'b1;
    chk("t1_valid", cdb_valid, 1'b1);
    chk("t1_result", cdb_result, 64'h2A);
    chk("t1_pr", cdb_dest_pr_idx, 7'd7);
    cyc(); clr();
    chk("t1_credit_back", rs_mult_avail, 2'b11);
    cyc();

    // 2: simultaneous completions, round robin
    do_reset();
    rs_issue = 2'b11; cyc(); clr();
    mult_done = 2'b11; mult_result0 = 64'h11; mult_result1 = 64'h22; cdb_grant = 1'b1; cyc();
    clr(); cdb_grant = 1'b1;
    chk("t2_first_lane", cdb_lane, 1'b0);
    chk("t2_first_res", cdb_result, 64'h11);
    cyc();
    chk("t2_second_lane", cdb_lane, 1'b1);
    chk("t2_second_res", cdb_result, 64'h22);
    cyc();
    rs_issue = 2'b01; cyc(); clr(); cdb_grant = 1'b1;
    mult_done = 2'b01; mult_result0 = 64'h55; cyc(); clr(); cdb_grant = 1'b1;
    cyc();
    rs_issue = 2'b11; cyc(); clr(); cdb_grant = 1'b1;
    mult_done = 2'b11; mult_result0 = 64'h11; mult_result1 = 64'h22; cyc();
    clr(); cdb_grant = 1'b1;
    chk("t2_rr_lane", cdb_lane, 1'b1);
    cyc();
    chk("t2_rr_next", cdb_lane, 1'b0);
    cyc();

    // 3: lane1 held without grant while lane0 arrives
    clr(); rs_issue = 2'b11; cyc(); clr();
    mult_done = 2'b10; mult_result1 = 64'h33; mult_dest_pr_idx1 = 7'd9; cyc(); clr();
    repeat (3) begin
      chk("t3_hold_lane", cdb_lane, 1'b1);
      chk("t3_hold_res", cdb_result, 64'h33);
      cyc();
    end
    mult_done = 2'b01; mult_result0 = 64'h44; cyc(); clr();
    chk("t3_still_lane1", cdb_lane, 1'b1);
    chk("t3_still_res", cdb_result, 64'h33);
    cdb_grant = 1'b1; cyc();
    chk("t3_then_lane0", cdb_lane, 1'b0);
    cyc(); clr();

    // 4: exhaust lane0 credits, fill FIFO, one grant restores availability
    repeat (4) begin rs_issue = 2'b01; cyc(); end
    clr();
    chk("t4_avail_zero", rs_mult_avail, 2'b10);
    for (int k = 0; k < 4; k++) begin
      mult_done = 2'b01; mult_result0 = 64'hA0 + 64'(k); cyc();
    end
    clr();
    chk("t4_head", cdb_result, 64'hA0);
    cdb_grant = 1'b1; cyc(); clr();
    chk("t4_avail_back", rs_mult_avail, 2'b11);

    // 5: push into a full FIFO with no grant
    mult_done = 2'b01; mult_result0 = 64'hB0; cyc();
    mult_done = 2'b01; mult_result0 = 64'hB1; cyc(); clr();
    chk("t5_err", overflow_err, 1'b1);
    chk("t5_head_kept", cdb_result, 64'hA1);
    repeat (2) cyc();
    chk("t5_err_sticky", overflow_err, 1'b1);

    // 6: asynchronous reset with three entries queued
    cdb_grant = 1'b1; cyc(); clr();
    chk("t6_pre_valid", cdb_valid, 1'b1);
    cdb_grant = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_valid", cdb_valid, 1'b0);
    chk("t6_result", cdb_result, 64'h0);
    chk("t6_pr", cdb_dest_pr_idx, 7'h0);
    chk("t6_ar", cdb_dest_ar_idx, 5'h0);
    chk("t6_we", prf_write_enable, 1'b0);
    chk("t6_avail", rs_mult_avail, 2'b11);
    chk("t6_err", overflow_err, 1'b0);
    clr();
    m_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    repeat (400) rand_cycle();
    clr();
    repeat (12) begin cdb_grant = 1'b1; cyc(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
